// File: rtl/count_down_timer_ctrl.sv
// count_down_timer_ctrl: button-driven edit/run/alarm sequencer for the count-down timer datapath.
// Optional buzzer self-silence timeout is built when ALARM_TIMEOUT_EN is defined.
module count_down_timer_ctrl #(
  parameter int MAX_HOUR     = 17,
  parameter int BLINK_CYCLES = 25000000,
  parameter int ALARM_CYCLES = 1500000000,
  parameter int ZERO_GUARD   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_reset,
  input  logic [7:0] remain_hour_bcd,
  input  logic [7:0] remain_minute_bcd,
  input  logic [7:0] remain_second_bcd,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       set_timer,
  output logic       reset_timer,
  output logic       pause,
  output logic       running,
  output logic [1:0] edit_field,
  output logic       blank,
  output logic       buzzer
);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int GW = $clog2(ZERO_GUARD + 2);
  localparam logic [7:0] HMAX = 8'((MAX_HOUR / 10) * 16 + MAX_HOUR % 10);
  typedef enum logic [3:0] {S_IDLE, S_HOUR, S_MIN, S_SEC, S_LOAD, S_RUN, S_PAUSE, S_ALARM} state_t;
  state_t state, state_n;
  logic [7:0] sh_hour, sh_minute, sh_second;
  logic [7:0] hour_n, minute_n, second_n, sh_hour_n, sh_minute_n, sh_second_n;
  logic [7:0] cur, cur_max, step;
  logic set_nx, reload_nx, pause_nx, blank_nx, zero, edit_n, restart, timeout, any_btn, blink_end;
  logic [1:0] field_nx;
  logic [BW-1:0] blink_cnt, blink_nx;
  logic [GW-1:0] guard, guard_nx;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return v == top ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    return v == 8'h00 ? top : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  assign zero = {remain_hour_bcd, remain_minute_bcd, remain_second_bcd} == 24'h0;
  assign any_btn = btn_mode | btn_up | btn_down | btn_start | btn_reset;
  assign cur = state == S_HOUR ? hour_bcd : state == S_MIN ? minute_bcd : second_bcd;
  assign cur_max = state == S_HOUR ? HMAX : 8'h59;
  assign step = btn_up ? bcd_inc(cur, cur_max) : bcd_dec(cur, cur_max);
  assign running = state == S_RUN;
`ifdef ALARM_TIMEOUT_EN
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  logic [AW-1:0] alarm_cnt;
  always_ff @(posedge clk)
    alarm_cnt <= (rst || state != S_ALARM) ? '0 : alarm_cnt + 1'b1;
  assign timeout = alarm_cnt == AW'(ALARM_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    hour_n = hour_bcd;
    minute_n = minute_bcd;
    second_n = second_bcd;
    sh_hour_n = sh_hour;
    sh_minute_n = sh_minute;
    sh_second_n = sh_second;
    set_nx = 1'b0;
    reload_nx = 1'b0;
    pause_nx = 1'b0;
    guard_nx = guard;
    case (state)
      S_IDLE:
        if (btn_reset) reload_nx = 1'b1;
        else if (btn_start) begin
          pause_nx = !zero;
          guard_nx = GW'(ZERO_GUARD);
          state_n = zero ? S_IDLE : S_RUN;
        end else if (btn_mode) begin
          sh_hour_n = hour_bcd;
          sh_minute_n = minute_bcd;
          sh_second_n = second_bcd;
          state_n = S_HOUR;
        end
      S_HOUR, S_MIN, S_SEC:
        if (btn_reset) begin
          hour_n = sh_hour;
          minute_n = sh_minute;
          second_n = sh_second;
          state_n = S_IDLE;
        end else if (btn_start) begin
          set_nx = 1'b1;
          state_n = S_LOAD;
        end else if (btn_mode) begin
          set_nx = state == S_SEC;
          state_n = state == S_HOUR ? S_MIN : state == S_MIN ? S_SEC : S_IDLE;
        end else if (btn_up || btn_down) begin
          hour_n = state == S_HOUR ? step : hour_bcd;
          minute_n = state == S_MIN ? step : minute_bcd;
          second_n = state == S_SEC ? step : second_bcd;
        end
      S_LOAD: begin
        pause_nx = {hour_bcd, minute_bcd, second_bcd} != 24'h0;
        guard_nx = GW'(ZERO_GUARD);
        state_n = pause_nx ? S_RUN : S_IDLE;
      end
      S_RUN:
        if (btn_reset) begin
          reload_nx = 1'b1;
          state_n = S_IDLE;
        end else if (btn_start) begin
          pause_nx = 1'b1;
          state_n = S_PAUSE;
        end else if (guard != '0) guard_nx = guard - 1'b1;
        else if (zero) state_n = S_ALARM;
      S_PAUSE:
        if (btn_reset) begin
          reload_nx = 1'b1;
          state_n = S_IDLE;
        end else if (btn_start) begin
          pause_nx = 1'b1;
          guard_nx = GW'(ZERO_GUARD);
          state_n = S_RUN;
        end
      S_ALARM:
        if (any_btn || timeout) begin
          reload_nx = 1'b1;
          state_n = S_IDLE;
        end
      default: state_n = S_IDLE;
    endcase
    edit_n = state_n inside {S_HOUR, S_MIN, S_SEC};
    // A field change or an up/down press restarts the blink so the field is shown at once.
    restart = state_n != state || btn_up || btn_down;
    blink_end = blink_cnt == BW'(BLINK_CYCLES - 1);
    blink_nx = (!edit_n || restart || blink_end) ? '0 : blink_cnt + 1'b1;
    blank_nx = edit_n && !restart && (blink_end ? !blank : blank);
    field_nx = state_n == S_HOUR ? 2'd1 : state_n == S_MIN ? 2'd2 : state_n == S_SEC ? 2'd3 :
               state_n == S_LOAD ? edit_field : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hour_bcd <= 8'h00;
      minute_bcd <= 8'h00;
      second_bcd <= 8'h00;
      sh_hour <= 8'h00;
      sh_minute <= 8'h00;
      sh_second <= 8'h00;
      set_timer <= 1'b0;
      reset_timer <= 1'b0;
      pause <= 1'b0;
      edit_field <= 2'd0;
      blank <= 1'b0;
      buzzer <= 1'b0;
      blink_cnt <= '0;
      guard <= '0;
    end else begin
      state <= state_n;
      hour_bcd <= hour_n;
      minute_bcd <= minute_n;
      second_bcd <= second_n;
      sh_hour <= sh_hour_n;
      sh_minute <= sh_minute_n;
      sh_second <= sh_second_n;
      set_timer <= set_nx;
      reset_timer <= reload_nx;
      pause <= pause_nx;
      edit_field <= field_nx;
      blank <= blank_nx;
      buzzer <= state_n == S_ALARM;
      blink_cnt <= blink_nx;
      guard <= guard_nx;
    end
  end
endmodule

// File: tb/tb_count_down_timer_ctrl.sv
// tb_count_down_timer_ctrl: random and directed stimulus against a behavioural model of the controller and datapath.
module tb_count_down_timer_ctrl;
  localparam int MAX_HOUR = 17, BLINK = 4, ACYC = 10, GUARD = 2;
  localparam logic [4:0] N = 5'b00000, R = 5'b10000, S = 5'b01000, M = 5'b00100, U = 5'b00010, D = 5'b00001;
  localparam int M_IDLE = 0, M_HOUR = 1, M_MIN = 2, M_SEC = 3, M_LOAD = 4, M_RUN = 5, M_PAUSE = 6, M_ALARM = 7;
  logic clk = 0, rst = 1;
  logic btn_mode = 0, btn_up = 0, btn_down = 0, btn_start = 0, btn_reset = 0;
  logic [7:0] remain_hour_bcd, remain_minute_bcd, remain_second_bcd, hour_bcd, minute_bcd, second_bcd;
  logic set_timer, reset_timer, pause, running, blank, buzzer;
  logic [1:0] edit_field;
  int checks = 0, errors = 0, n_set = 0;
  int dp = 0, dp_q1 = 0, dp_q2 = 0, dp_bak = 0, dp_tick = 0;
  bit dp_en = 0, dp_clr = 0;
  int mode = 0, fh = 0, fm = 0, fs = 0, sh = 0, sm = 0, ss = 0, field = 0, blink_k = 0, run_age = 0, alarm_age = 0;
  bit e_set = 0, e_rel = 0, e_pause = 0, model_ok = 0;
  always #5 clk = ~clk;
  count_down_timer_ctrl #(.MAX_HOUR(MAX_HOUR), .BLINK_CYCLES(BLINK), .ALARM_CYCLES(ACYC), .ZERO_GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
    .btn_reset(btn_reset), .remain_hour_bcd(remain_hour_bcd), .remain_minute_bcd(remain_minute_bcd),
    .remain_second_bcd(remain_second_bcd), .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .set_timer(set_timer), .reset_timer(reset_timer), .pause(pause), .running(running), .edit_field(edit_field),
    .blank(blank), .buzzer(buzzer));
  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic int wrap(input int v, input int top, input bit up);
    return up ? (v == top ? 0 : v + 1) : (v == 0 ? top : v - 1);
  endfunction
  assign remain_hour_bcd = bcd(dp_q2 / 3600);
  assign remain_minute_bcd = bcd((dp_q2 / 60) % 60);
  assign remain_second_bcd = bcd(dp_q2 % 60);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mode = M_IDLE; fh = 0; fm = 0; fs = 0; sh = 0; sm = 0; ss = 0; field = 0; blink_k = 0;
    e_set = 0; e_rel = 0; e_pause = 0; dp_clr = 1; model_ok = 1;
  endtask
  task automatic model_step();
    int w, pm;
    bit tmo;
    w = btn_reset ? 1 : btn_start ? 2 : btn_mode ? 3 : btn_up ? 4 : btn_down ? 5 : 0;
    pm = mode; e_set = 0; e_rel = 0; e_pause = 0; dp_clr = 0;
    case (mode)
      M_IDLE:
        if (w == 1) e_rel = 1;
        else if (w == 2) begin
          if (dp_q2 != 0) begin e_pause = 1; mode = M_RUN; run_age = 0; end
        end else if (w == 3) begin sh = fh; sm = fm; ss = fs; mode = M_HOUR; end
      M_HOUR, M_MIN, M_SEC:
        if (w == 1) begin fh = sh; fm = sm; fs = ss; mode = M_IDLE; end
        else if (w == 2) begin e_set = 1; mode = M_LOAD; end
        else if (w == 3) begin e_set = mode == M_SEC; mode = mode == M_SEC ? M_IDLE : mode + 1; end
        else if (w >= 4) begin
          if (mode == M_HOUR) fh = wrap(fh, MAX_HOUR, w == 4);
          else if (mode == M_MIN) fm = wrap(fm, 59, w == 4);
          else fs = wrap(fs, 59, w == 4);
        end
      M_LOAD:
        if (fh * 3600 + fm * 60 + fs != 0) begin e_pause = 1; mode = M_RUN; run_age = 0; end
        else mode = M_IDLE;
      M_RUN:
        if (w == 1) begin e_rel = 1; mode = M_IDLE; end
        else if (w == 2) begin e_pause = 1; mode = M_PAUSE; end
        else begin
          run_age++;
          if (run_age > GUARD && dp_q2 == 0) begin mode = M_ALARM; alarm_age = 0; end
        end
      M_PAUSE:
        if (w == 1) begin e_rel = 1; mode = M_IDLE; end
        else if (w == 2) begin e_pause = 1; mode = M_RUN; run_age = 0; end
      default: begin
        alarm_age++;
`ifdef ALARM_TIMEOUT_EN
        tmo = alarm_age == ACYC;
`else
        tmo = 0;
`endif
        if (w != 0 || tmo) begin e_rel = 1; mode = M_IDLE; end
      end
    endcase
    if (mode >= M_HOUR && mode <= M_SEC) begin
      field = mode;
      blink_k = (mode != pm || w >= 4) ? 0 : blink_k + 1;
    end else if (mode != M_LOAD) field = 0;
  endtask
  // Datapath stand-in: outputs lag its state by two cycles so the zero guard is exercised.
  always @(negedge clk) begin
    dp_q1 <= dp;
    dp_q2 <= dp_q1;
    if (dp_clr) begin
      dp <= 0; dp_q1 <= 0; dp_q2 <= 0; dp_bak <= 0; dp_en <= 0; dp_tick <= 0;
    end else if (e_set) begin
      dp <= fh * 3600 + fm * 60 + fs; dp_bak <= fh * 3600 + fm * 60 + fs; dp_en <= 0; dp_tick <= 0;
    end else if (e_rel) begin
      dp <= dp_bak; dp_en <= 0; dp_tick <= 0;
    end else begin
      if (e_pause) dp_en <= !dp_en;
      if (dp_en && dp > 0) begin
        dp_tick <= dp_tick == 2 ? 0 : dp_tick + 1;
        if (dp_tick == 2) dp <= dp - 1;
      end
    end
  end
  always @(negedge clk) if (model_ok) begin
    chk("hour_bcd", 32'(hour_bcd), 32'(bcd(fh)));
    chk("minute_bcd", 32'(minute_bcd), 32'(bcd(fm)));
    chk("second_bcd", 32'(second_bcd), 32'(bcd(fs)));
    chk("set_timer", 32'(set_timer), 32'(e_set));
    chk("reset_timer", 32'(reset_timer), 32'(e_rel));
    chk("pause", 32'(pause), 32'(e_pause));
    chk("running", 32'(running), 32'(mode == M_RUN));
    chk("edit_field", 32'(edit_field), 32'(field));
    chk("blank", 32'(blank), 32'((mode >= M_HOUR && mode <= M_SEC) ? (blink_k / BLINK) % 2 : 0));
    chk("buzzer", 32'(buzzer), 32'(mode == M_ALARM));
    if (set_timer) n_set++;
  end
  task automatic cyc(input logic [4:0] b, input logic r);
    {btn_reset, btn_start, btn_mode, btn_up, btn_down} = b;
    rst = r;
    @(posedge clk);
    if (r) model_reset(); else model_step();
    @(negedge clk);
  endtask
  task automatic press(input logic [4:0] b);
    cyc(b, 0);
    cyc(N, 0);
  endtask
  task automatic wait_buzz();
    for (int i = 0; i < 200 && !buzzer; i++) cyc(N, 0);
    chk("alarm_reached", 32'(buzzer), 32'd1);
  endtask
  initial begin
    int n0, n;
    logic [4:0] b;
    @(negedge clk);
    repeat (3) cyc(N, 1);
    chk("rst_hour", 32'(hour_bcd), 32'h00);
    chk("rst_buzzer", 32'(buzzer), 32'd0);
    chk("rst_field", 32'(edit_field), 32'd0);
    cyc(N, 0);
    n0 = n_set;
    press(M); repeat (3) press(U); press(M); press(D); press(M); repeat (5) press(U); press(M);
    cyc(N, 0);
    chk("seq_hour", 32'(hour_bcd), 32'h03);
    chk("seq_minute", 32'(minute_bcd), 32'h59);
    chk("seq_second", 32'(second_bcd), 32'h05);
    chk("seq_set_pulses", 32'(n_set - n0), 32'd1);
    chk("seq_idle_field", 32'(edit_field), 32'd0);
    cyc(N, 1);
    press(M); repeat (17) press(U);
    chk("hour_max", 32'(hour_bcd), 32'h17);
    press(U);
    chk("hour_wrap", 32'(hour_bcd), 32'h00);
    press(M); press(D);
    chk("minute_wrap", 32'(minute_bcd), 32'h59);
    press(R);
    chk("cancel_minute", 32'(minute_bcd), 32'h00);
    press(M); repeat (2) press(U); press(M); press(M); press(M);
    press(M); press(M); repeat (7) press(U);
    chk("edit_minute", 32'(minute_bcd), 32'h07);
    cyc(R, 0);
    chk("restore_minute", 32'(minute_bcd), 32'h00);
    chk("restore_hour", 32'(hour_bcd), 32'h02);
    chk("restore_nostrobe", 32'({set_timer, reset_timer, pause}), 32'd0);
    cyc(N, 1);
    press(M); press(M); press(M); press(U); press(U);
    cyc(S, 0);
    chk("load_set", 32'(set_timer), 32'd1);
    chk("load_field", 32'(edit_field), 32'd3);
    cyc(N, 0);
    chk("load_pause", 32'(pause), 32'd1);
    chk("load_running", 32'(running), 32'd1);
    wait_buzz();
    chk("alarm_remain", 32'({remain_hour_bcd, remain_minute_bcd, remain_second_bcd}), 32'd0);
    cyc(U, 0);
    chk("alarm_clear_buzz", 32'(buzzer), 32'd0);
    chk("alarm_clear_reload", 32'(reset_timer), 32'd1);
    repeat (4) cyc(N, 0);
    cyc(S, 0);
    chk("run_pause1", 32'(pause), 32'd1);
    chk("run_on1", 32'(running), 32'd1);
    cyc(N, 0);
    cyc(S, 0);
    chk("run_pause2", 32'(pause), 32'd1);
    chk("run_off", 32'(running), 32'd0);
    cyc(N, 0);
    cyc(S, 0);
    chk("run_on2", 32'(running), 32'd1);
    cyc(N, 0);
    cyc(R | S, 0);
    chk("prio_reload", 32'(reset_timer), 32'd1);
    chk("prio_nopause", 32'(pause), 32'd0);
    chk("prio_idle", 32'(running), 32'd0);
    repeat (4) cyc(N, 0);
    cyc(S, 0);
    cyc(N, 0);
    cyc(N, 1);
    chk("midrst_outs", 32'({running, pause, set_timer, reset_timer, buzzer, blank, edit_field}), 32'd0);
    chk("midrst_fields", 32'({hour_bcd, minute_bcd, second_bcd}), 32'd0);
`ifdef ALARM_TIMEOUT_EN
    press(M); press(M); press(M); press(U); press(M);
    repeat (3) cyc(N, 0);
    cyc(S, 0);
    wait_buzz();
    n = 0;
    while (buzzer && n < 50) begin cyc(N, 0); n++; end
    chk("timeout_len", 32'(n), 32'(ACYC));
    chk("timeout_reload", 32'(reset_timer), 32'd1);
`endif
    for (int i = 0; i < 1500; i++) begin
      n = $urandom_range(0, 31);
      b = n < 10 ? 5'(1 << $urandom_range(0, 4)) : n == 10 ? 5'($urandom_range(0, 31)) : N;
      cyc(b, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 39);
      b = n == 0 ? 5'(1 << $urandom_range(0, 4)) : n == 1 ? 5'($urandom_range(0, 31)) : N;
      cyc(b, $urandom_range(0, 999) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_down_timer_ctrl.md
Name: count_down_timer_ctrl

Overview:
User-facing sequencer for the count-down timer datapath. It turns debounced single-cycle button pulses into an edit session for the hours, minutes and seconds BCD fields. It also drives the datapath's set_timer, reset_timer and pause strobes, tracks run/pause state, and raises the buzzer when the remaining time reaches 00:00:00. It sits between the button debouncers and the count_down_timer instance, in the same clk domain.

Parameters:
MAX_HOUR, 17, highest editable hour (binary); 17:59:59 fits the 16-bit datapath seconds count.
BLINK_CYCLES, 25000000, clk cycles per blink half-period for the field being edited.
ALARM_CYCLES, 1500000000, clk cycles before the buzzer self-silences (optional feature only).
ZERO_GUARD, 2, cycles after a start/resume strobe during which zero detection is ignored (covers datapath output latency).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_mode  in  1  one-cycle pulse: enter edit / advance field
btn_up  in  1  one-cycle pulse: increment current field
btn_down  in  1  one-cycle pulse: decrement current field
btn_start  in  1  one-cycle pulse: start/pause/resume
btn_reset  in  1  one-cycle pulse: reload/cancel
remain_hour_bcd  in  8  datapath hour output
remain_minute_bcd  in  8  datapath minute output
remain_second_bcd  in  8  datapath second output
hour_bcd  out  8  edited hour, drives datapath hour_bcd_in
minute_bcd  out  8  edited minute, drives datapath minute_bcd_in
second_bcd  out  8  edited second, drives datapath second_bcd_in
set_timer  out  1  one-cycle load strobe
reset_timer  out  1  one-cycle reload strobe
pause  out  1  one-cycle enable-toggle strobe
running  out  1  high in RUNNING
edit_field  out  2  0 none, 1 hour, 2 minute, 3 second
blank  out  1  high during blink off-phase while editing
buzzer  out  1  alarm output

Behaviour:
- Reset (rst high on a clk edge), highest priority, valid in any state:
  - state IDLE; hour/minute/second_bcd 8'h00; shadow copies 8'h00.
  - All strobes 0; running 0, edit_field 0, blank 0, buzzer 0.
  - Blink, guard and alarm counters cleared.
- Button priority when several pulse in one cycle: reset > start > mode > up > down. Only the winner acts.
- All strobes are registered, exactly one cycle wide, and never two strobes in the same cycle.
- States and transitions:
  - IDLE:
    - mode -> EDIT_HOUR; copy the edit registers into the shadow.
    - start with remaining nonzero -> pause strobe, go to RUNNING, arm the guard.
    - start with remaining zero -> ignored.
    - reset -> reset_timer strobe, stay in IDLE.
  - EDIT_HOUR / EDIT_MIN / EDIT_SEC:
    - up/down change the current field with BCD wrap: hour MAX_HOUR<->00, minute and second 59<->00.
    - mode advances HOUR->MIN->SEC. From SEC, mode issues a set_timer strobe and goes to IDLE.
    - start -> LOAD.
    - reset -> restore the edit registers from the shadow, go to IDLE, no strobe.
  - LOAD:
    - Cycle 1: set_timer strobe.
    - Cycle 2: if the edited value is nonzero, pause strobe and go to RUNNING (guard armed); otherwise go to IDLE.
    - Buttons are ignored in LOAD.
  - RUNNING:
    - start -> pause strobe, go to PAUSED.
    - reset -> reset_timer strobe, go to IDLE.
    - Remaining value 00:00:00 with the guard expired -> ALARM, buzzer 1.
    - mode, up and down are ignored.
  - PAUSED:
    - start -> pause strobe, go to RUNNING, re-arm the guard.
    - reset -> reset_timer strobe, go to IDLE.
  - ALARM:
    - buzzer held at 1.
    - Any button pulse -> buzzer 0, reset_timer strobe (datapath reloads the backup value), go to IDLE.
- Zero test compares all 24 remain bits against 0.
- Edit-field increments are decimal on BCD digits; no binary conversion inside the block.
- edit_field is 1/2/3 in EDIT states and also while in LOAD. blank toggles every BLINK_CYCLES in EDIT states and is 0 elsewhere. The blink counter restarts at 0 on every field change and on every up/down press, so the field is visible immediately.

Optional Feature:
- Macro: ALARM_TIMEOUT_EN.
- Defined: a counter runs in ALARM. After ALARM_CYCLES cycles with no button, the block behaves as if a button had been pressed: buzzer 0, reset_timer strobe, go to IDLE.
- Undefined: buzzer stays high until a button press; no timeout counter is synthesised.

Test Plan:
- Reset, then mode, up×3, mode, down×1, mode, up×5, mode -> hour_bcd 8'h03, minute_bcd 8'h59, second_bcd 8'h05; exactly one set_timer pulse; state IDLE.
- Edit hour with MAX_HOUR=17: up×18 from 00 -> 17 then 00. Edit minute: down from 00 -> 59.
- Edit to 00:00:02 and press start -> set_timer, then pause on the next cycle, running=1. Model remain counting to 00:00:00 -> buzzer=1 on the cycle after zero is seen (guard respected). btn_up -> buzzer 0 and a reset_timer pulse.
- While RUNNING: start -> pause pulse, running=0; start again -> pause pulse, running=1. Same cycle start+reset -> only reset_timer, state IDLE.
- Edit minute to 07, then reset -> minute_bcd returns to the previous committed value; no strobe.
- With ALARM_TIMEOUT_EN and ALARM_CYCLES=10: enter ALARM -> buzzer drops after 10 cycles with a reset_timer pulse. rst asserted mid-RUNNING -> all outputs return to reset values on the next edge.
